fifo_sync_param: RTL and testbench

//  Parametrised single-clock FIFO, the next generation of the fifo_if-connected FIFO DUT.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_ram.sv | 26 ++
 rtl/fifo_sync_param.sv | 141 ++++++++++++++
 tb/tb_fifo_sync_param.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and default constants for the parametrised synchronous FIFO.
// The read mode is an enum so instances name the mode instead of using a bare bit.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_DEPTH      = 16;
  localparam int unsigned DEF_AF_THRESH  = 14;
  localparam int unsigned DEF_AE_THRESH  = 2;
  localparam fifo_mode_e  DEF_MODE       = FIFO_STD;

  function automatic bit is_pow2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module fifo_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with thresholds, fill count, sticky error flags,
// synchronous flush and selectable standard / first-word-fall-through read mode.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned AF_THRESH  = DEF_AF_THRESH,
  parameter int unsigned AE_THRESH  = DEF_AE_THRESH,
  parameter fifo_mode_e  FWFT       = DEF_MODE,
  localparam int unsigned ADDR_W    = $clog2(DEPTH),
  localparam int unsigned CNT_W     = ADDR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  underflow
);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of two and >= 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("fifo_sync_param: AF_THRESH must lie in 1..DEPTH");
  end
  if (AE_THRESH >= DEPTH) begin : g_bad_ae
    $error("fifo_sync_param: AE_THRESH must lie in 0..DEPTH-1");
  end

  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Handshake: wr_en/rd_en are requests sampled on the rising edge. A write is taken
  // iff wr_en && !full, a read iff rd_en && !empty, judged on the registered count;
  // a rejected request is dropped (never retried) and raises its sticky error flag.
  // A clr cycle takes nothing and flags nothing.
  assign wr_acc = wr_en && !full  && !clr;
  assign rd_acc = rd_en && !empty && !clr;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (wr_en && full) begin
        overflow_d = 1'b1;
      end
      if (rd_en && empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // FWFT exposes the head directly; standard mode captures it on each accepted read.
  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign rd_data = ram_rdata;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q <= '0;
      end else if (rd_acc) begin
        rd_data_q <= ram_rdata;
      end
    end

    assign rd_data = rd_data_q;
  end

  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_W'(DEPTH));
  assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
  assign almost_empty = (count_q <= CNT_W'(AE_THRESH));
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a standard-mode and a FWFT instance share one stimulus
// stream and are compared every cycle against a queue-based model, plus literal checks.
module tb_fifo_sync_param;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int AF = 6;
  localparam int AE = 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, clr, wr_en, rd_en;
  logic [DW-1:0] wr_data;

  logic          s_full, s_af, s_empty, s_ae, s_ovf, s_unf;
  logic [DW-1:0] s_rd_data;
  logic [3:0]    s_count;
  logic          f_full, f_af, f_empty, f_ae, f_ovf, f_unf;
  logic [DW-1:0] f_rd_data;
  logic [3:0]    f_count;

  fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE),
                    .FWFT(FIFO_STD)) u_std (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .full(s_full), .almost_full(s_af), .rd_en(rd_en), .rd_data(s_rd_data),
    .empty(s_empty), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf));

  fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE),
                    .FWFT(FIFO_FWFT)) u_fwft (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .full(f_full), .almost_full(f_af), .rd_en(rd_en), .rd_data(f_rd_data),
    .empty(f_empty), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: exp_q holds the FIFO contents in order, head at index 0
  logic [DW-1:0] exp_q[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;
  logic [DW-1:0] m_rd = '0;
  bit            model_on = 1'b0;
  int            m_sz;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rd = '0;
      model_on = 1'b1;
    end else if (clr) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_sz = exp_q.size();
      if (wr_en && m_sz == DEPTH) m_ovf = 1'b1;
      if (rd_en && m_sz == 0) m_unf = 1'b1;
      if (rd_en && m_sz > 0) m_rd = exp_q.pop_front();
      if (wr_en && m_sz < DEPTH) exp_q.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("count", s_count, exp_q.size());
      check("empty", s_empty, exp_q.size() == 0);
      check("full", s_full, exp_q.size() == DEPTH);
      check("almost_empty", s_ae, exp_q.size() <= AE);
      check("almost_full", s_af, exp_q.size() >= AF);
      check("overflow", s_ovf, m_ovf);
      check("underflow", s_unf, m_unf);
      check("std_rd_data", s_rd_data, m_rd);
      check("fwft_count", f_count, exp_q.size());
      check("fwft_empty", f_empty, exp_q.size() == 0);
      check("fwft_flags", {f_full, f_af, f_ae, f_ovf, f_unf},
            {exp_q.size() == DEPTH, exp_q.size() >= AF, exp_q.size() <= AE, m_ovf, m_unf});
      if (exp_q.size() != 0) check("fwft_rd_data", f_rd_data, exp_q[0]);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic w, input logic r, input logic [DW-1:0] d);
    wr_en = w;
    rd_en = r;
    wr_data = d;
  endtask

  task automatic do_clr();
    set_in(1'b0, 1'b0, 8'h00);
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"}, s_count, 0);
    check({tag, "_empty"}, s_empty, 1);
    check({tag, "_full"}, s_full, 0);
    check({tag, "_ae"}, s_ae, 1);
    check({tag, "_af"}, s_af, 0);
    check({tag, "_ovf"}, s_ovf, 0);
    check({tag, "_unf"}, s_unf, 0);
    check({tag, "_rd_data"}, s_rd_data, 0);
  endtask

  int wr_pct, rd_pct;

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    set_in(1'b0, 1'b0, 8'h00);
    tick();
    tick();
    rst = 1'b0;
    check_reset_values("reset");

    // fill 0x11..0x18, almost_full from count 6
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 1'b0, 8'(8'h11 + i));
      tick();
      check("fill_count", s_count, i + 1);
      check("fill_af", s_af, (i + 1) >= 6);
    end
    check("fill_full", s_full, 1);
    set_in(1'b1, 1'b0, 8'h99);
    tick();
    check("ovf_set", s_ovf, 1);
    check("ovf_count", s_count, 8);

    // drain, data one cycle after each rd_en
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 1'b1, 8'h00);
      tick();
      check("drain_rd_data", s_rd_data, 8'h11 + i);
    end
    check("drain_empty", s_empty, 1);
    tick();
    set_in(1'b0, 1'b0, 8'h00);
    check("unf_set", s_unf, 1);
    check("unf_rd_hold", s_rd_data, 8'h18);

    // steady wr+rd at count 4, pointers wrap
    do_clr();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b0, 8'(8'h20 + i));
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 1'b1, 8'(8'h30 + i));
      tick();
      check("steady_count", s_count, 4);
      check("steady_rd_data", s_rd_data, (i < 4) ? (8'h20 + i) : (8'h30 + i - 4));
    end

    // full + wr/rd: read the head, drop the write
    do_clr();
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 1'b0, 8'(8'h40 + i));
      tick();
    end
    set_in(1'b1, 1'b1, 8'hEE);
    tick();
    check("fullwr_rd_data", s_rd_data, 8'h40);
    check("fullwr_count", s_count, 7);
    check("fullwr_ovf", s_ovf, 1);
    for (int i = 0; i < 7; i++) begin
      set_in(1'b0, 1'b1, 8'h00);
      tick();
      check("fullwr_drain", s_rd_data, 8'h41 + i);
    end

    // empty + wr/rd: take the write, reject the read
    do_clr();
    set_in(1'b1, 1'b1, 8'h55);
    tick();
    set_in(1'b0, 1'b0, 8'h00);
    check("emptywr_count", s_count, 1);
    check("emptywr_unf", s_unf, 1);
    check("emptywr_ovf", s_ovf, 0);
    check("emptywr_rd_hold", s_rd_data, 8'h47);
    check("emptywr_fwft_data", f_rd_data, 8'h55);

    // FWFT: word visible one cycle after the write, no rd_en
    do_clr();
    check("fwft_empty_before", f_empty, 1);
    set_in(1'b1, 1'b0, 8'hA5);
    tick();
    set_in(1'b0, 1'b0, 8'h00);
    check("fwft_empty_after", f_empty, 0);
    check("fwft_a5", f_rd_data, 8'hA5);
    tick();
    check("fwft_a5_hold", f_rd_data, 8'hA5);

    // clr at count 5 with both flags set and requests pending
    do_clr();
    set_in(1'b0, 1'b1, 8'h00);
    tick();
    for (int i = 0; i < 9; i++) begin
      set_in(1'b1, 1'b0, 8'(8'h60 + i));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b1, 8'h00);
      tick();
    end
    check("preclr_count", s_count, 5);
    check("preclr_flags", {s_ovf, s_unf}, 2'b11);
    set_in(1'b1, 1'b1, 8'h77);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    set_in(1'b0, 1'b0, 8'h00);
    check("clr_count", s_count, 0);
    check("clr_empty", s_empty, 1);
    check("clr_flags", {s_ovf, s_unf}, 2'b00);
    check("clr_rd_hold", s_rd_data, 8'h62);

    // randomized traffic with shifting fill bias, occasional clr/rst
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        wr_pct = $urandom_range(15, 85);
        rd_pct = $urandom_range(15, 85);
      end
      rst = ($urandom_range(0, 399) == 0);
      clr = ($urandom_range(0, 99) == 0);
      set_in($urandom_range(0, 99) < wr_pct, $urandom_range(0, 99) < rd_pct,
             8'($urandom_range(0, 255)));
      tick();
    end
    rst = 1'b0;
    clr = 1'b0;

    // rst mid-stream overrides pending requests
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b1, 8'(8'hC0 + i));
      tick();
    end
    set_in(1'b1, 1'b1, 8'hDD);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_in(1'b0, 1'b0, 8'h00);
    check_reset_values("midrst");
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
